// File: rtl/jk_seq_pkg.sv
// Shared types and JK excitation codes for the JK sequence driver.
// Latency: none (declarations and a pure function only).
// Backpressure: not applicable.
package jk_seq_pkg;

   // Sequencer states: idle, one excitation cycle, one verification cycle, end pulse.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Two-bit JK codes, packed as {J, K}.
   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_CLR  = 2'b01;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_TGL  = 2'b11;

   // Pick the JK code that moves one flop from q to t.
   // The toggle style flips any differing bit with J=K=1; the
   // set/clear style never uses the toggle code, so a bit whose Q is
   // stale or unknown still lands on the target value.
   function automatic logic [1:0] jk_code(input logic q, input logic t, input logic use_toggle);
      logic [1:0] code;
      code = JK_HOLD;
      if (q != t) begin
         if (use_toggle) begin
            code = JK_TGL;
         end else if (t) begin
            code = JK_SET;
         end else begin
            code = JK_CLR;
         end
      end
      return code;
   endfunction

endpackage

// File: rtl/jk_excite.sv
// Per-bit JK excitation that moves a register bank from q_i to t_i.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the outputs always follow the inputs.
module jk_excite
   import jk_seq_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int USE_TOGGLE = 0
) (
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] t_i,
   output logic [WIDTH-1:0] j_o,
   output logic [WIDTH-1:0] k_o
);

   localparam logic TOGGLE_STYLE = (USE_TOGGLE != 0);

   // Split each bit's {J,K} code onto the two excitation buses.
   always_comb begin
      logic [1:0] code;
      code = JK_HOLD;
      j_o  = '0;
      k_o  = '0;
      for (int b = 0; b < WIDTH; b++) begin
         code   = jk_code(q_i[b], t_i[b], TOGGLE_STYLE);
         j_o[b] = code[1];
         k_o[b] = code[0];
      end
   end

endmodule

// File: rtl/jk_sequence_driver.sv
// Steps an external JK flip-flop bank through a stored list of target states.
// Latency: 2 cycles per step (DRIVE then CHECK); N-step run gives done 2N cycles after start.
// Backpressure: none; start and load_en are ignored while a run is busy.
module jk_sequence_driver
   import jk_seq_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int DEPTH      = 8,
   parameter int AW         = 3,
   parameter int USE_TOGGLE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_en,
   input  logic [AW-1:0]    load_addr,
   input  logic [WIDTH-1:0] load_data,
   input  logic [AW-1:0]    last_addr,
   input  logic             loop,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] q_in,
   output logic [WIDTH-1:0] j_out,
   output logic [WIDTH-1:0] k_out,
   output logic             step_valid,
   output logic [AW-1:0]    step_idx,
   output logic             busy,
   output logic             done,
   output logic             mismatch,
   output logic [AW-1:0]    err_idx
);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_e           state_q, state_d;
   logic [AW-1:0]    idx_q, idx_d;
   logic [AW-1:0]    last_q, last_d;
   logic             loop_q, loop_d;
   logic             mismatch_q, mismatch_d;
   logic [AW-1:0]    err_idx_q, err_idx_d;

   // Target memory; deliberately not reset so a program survives rst.
   logic [WIDTH-1:0] mem_q [DEPTH];

   // ------------------------------------------------------------------
   // Decode helpers
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] target;
   logic [WIDTH-1:0] j_exc;
   logic [WIDTH-1:0] k_exc;
   logic             start_ok;
   logic             load_ok;
   logic             at_last;
   logic             step_fail;

   assign target    = mem_q[idx_q];
   // abort beats start in IDLE, so a coincident pair never launches a run.
   assign start_ok  = (state_q == ST_IDLE) && start && !abort;
   assign load_ok   = load_en && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign at_last   = (idx_q == last_q);
   assign step_fail = (q_in != target);

   jk_excite #(
      .WIDTH      (WIDTH),
      .USE_TOGGLE (USE_TOGGLE)
   ) u_excite (
      .q_i (q_in),
      .t_i (target),
      .j_o (j_exc),
      .k_o (k_exc)
   );

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------

   // State register; reset overrides everything, including an active run.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: one DRIVE/CHECK pair per step, abort exits without a done pulse.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               state_d = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            state_d = abort ? ST_IDLE : ST_CHECK;
         end
         ST_CHECK: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (at_last && !loop_q) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_DRIVE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs: excitation is live only in DRIVE so the bank holds otherwise.
   always_comb begin
      j_out      = '0;
      k_out      = '0;
      step_valid = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      unique case (state_q)
         ST_DRIVE: begin
            j_out      = j_exc;
            k_out      = k_exc;
            step_valid = 1'b1;
            busy       = 1'b1;
         end
         ST_CHECK: begin
            busy = 1'b1;
         end
         ST_DONE: begin
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   assign step_idx = idx_q;
   assign mismatch = mismatch_q;
   assign err_idx  = err_idx_q;

   // ------------------------------------------------------------------
   // Run context: step index, captured bounds, sticky error record
   // ------------------------------------------------------------------

   // Next values for the index, captured run parameters and error record.
   always_comb begin
      idx_d      = idx_q;
      last_d     = last_q;
      loop_d     = loop_q;
      mismatch_d = mismatch_q;
      err_idx_d  = err_idx_q;

      if (start_ok) begin
         idx_d      = '0;
         last_d     = last_addr;
         loop_d     = loop;
         mismatch_d = 1'b0;
         err_idx_d  = '0;
      end

      if (state_q == ST_CHECK) begin
         // Only the first failing step is remembered.
         if (step_fail && !mismatch_q) begin
            mismatch_d = 1'b1;
            err_idx_d  = idx_q;
         end
         if (!abort) begin
            if (!at_last) begin
               idx_d = idx_q + AW'(1);
            end else if (loop_q) begin
               idx_d = '0;
            end
         end
      end
   end

   // Run-context registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q      <= '0;
         last_q     <= '0;
         loop_q     <= 1'b0;
         mismatch_q <= 1'b0;
         err_idx_q  <= '0;
      end else begin
         idx_q      <= idx_d;
         last_q     <= last_d;
         loop_q     <= loop_d;
         mismatch_q <= mismatch_d;
         err_idx_q  <= err_idx_d;
      end
   end

   // Target memory write port; a write in the start cycle lands before step 0 reads it.
   always_ff @(posedge clk) begin
      if (!rst && load_ok) begin
         mem_q[load_addr] <= load_data;
      end
   end

endmodule

// File: tb/tb_jk_sequence_driver.sv
module tb_jk_sequence_driver;
   localparam int W  = 4;
   localparam int AW = 3;
   localparam int D  = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1, load_en = 1'b0, start = 1'b0, abort = 1'b0, loop_i = 1'b0;
   logic [AW-1:0] load_addr = '0, last_addr = '0;
   logic [W-1:0]  load_data = '0;

   // External JK banks (one per DUT variant); stuck forces bits to 0.
   logic [W-1:0]  bq0, bq1, stuck = '0;
   logic          bank_rst = 1'b1;

   logic [W-1:0]  j0, k0, j1, k1;
   logic          sv0, busy0, done0, mis0, sv1, busy1, done1, mis1;
   logic [AW-1:0] idx0, err0, idx1, err1;

   jk_sequence_driver #(.WIDTH(W), .DEPTH(D), .AW(AW), .USE_TOGGLE(0)) dut_sc (
      .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .last_addr(last_addr), .loop(loop_i), .start(start), .abort(abort), .q_in(bq0),
      .j_out(j0), .k_out(k0), .step_valid(sv0), .step_idx(idx0), .busy(busy0),
      .done(done0), .mismatch(mis0), .err_idx(err0));

   jk_sequence_driver #(.WIDTH(W), .DEPTH(D), .AW(AW), .USE_TOGGLE(1)) dut_tg (
      .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .last_addr(last_addr), .loop(loop_i), .start(start), .abort(abort), .q_in(bq1),
      .j_out(j1), .k_out(k1), .step_valid(sv1), .step_idx(idx1), .busy(busy1),
      .done(done1), .mismatch(mis1), .err_idx(err1));

   // JK flop characteristic: Q+ = J&~Q | ~K&Q.
   function automatic logic [W-1:0] jk_next(input logic [W-1:0] q, j, k);
      return (j & ~q) | (~k & q);
   endfunction

   always @(posedge clk) begin
      if (bank_rst) begin
         bq0 <= '0;
         bq1 <= '0;
      end else begin
         bq0 <= jk_next(bq0, j0, k0) & ~stuck;
         bq1 <= jk_next(bq1, j1, k1) & ~stuck;
      end
   end

   int n_cmp = 0, n_fail = 0;

   // Reference model of the programmed run.
   logic [W-1:0] mem_m [D];
   int m_idx, m_last, m_err, m_cyc;
   bit m_loop, m_mis, m_end;

   task automatic write_mem(input int a, input logic [W-1:0] d);
      load_addr = a[AW-1:0]; load_data = d; load_en = 1'b1;
      @(posedge clk); #1;
      load_en = 1'b0;
      mem_m[a] = d;
   endtask

   task automatic start_run(input int last, input bit lp);
      last_addr = last[AW-1:0]; loop_i = lp; start = 1'b1;
      m_last = last; m_loop = lp; m_idx = 0; m_mis = 0; m_err = 0; m_end = 0; m_cyc = 0;
      @(posedge clk); #1;
      start = 1'b0; load_en = 1'b0;
   endtask

   // Observes one DRIVE cycle and its CHECK cycle, advancing the model.
   task automatic do_step(input string tag);
      logic [W-1:0] t, eq, ej0, ek0, et;
      t   = mem_m[m_idx];
      ej0 = t & ~bq0;          // bits that must rise are set
      ek0 = bq0 & ~t;          // bits that must fall are cleared
      et  = bq1 ^ t;           // toggle style: every differing bit flips
      n_cmp++;
      if ({sv0, busy0, done0, sv1, busy1} !== 5'b11011) begin
         n_fail++; $display("FAIL %s drive_flags step %0d: got %b want 11011", tag, m_idx, {sv0, busy0, done0, sv1, busy1});
      end
      n_cmp++;
      if (idx0 !== m_idx[AW-1:0] || idx1 !== m_idx[AW-1:0]) begin
         n_fail++; $display("FAIL %s step_idx: got %0d/%0d want %0d", tag, idx0, idx1, m_idx);
      end
      n_cmp++;
      if (j0 !== ej0 || k0 !== ek0) begin
         n_fail++; $display("FAIL %s setclr_jk step %0d: got %b/%b want %b/%b", tag, m_idx, j0, k0, ej0, ek0);
      end
      n_cmp++;
      if (j1 !== et || k1 !== et) begin
         n_fail++; $display("FAIL %s toggle_jk step %0d: got %b/%b want %b/%b", tag, m_idx, j1, k1, et, et);
      end
      @(posedge clk); #1;
      start = 1'b0; load_en = 1'b0;
      eq = t & ~stuck;
      n_cmp++;
      if (bq0 !== eq || bq1 !== eq) begin
         n_fail++; $display("FAIL %s bank_q step %0d: got %h/%h want %h", tag, m_idx, bq0, bq1, eq);
      end
      n_cmp++;
      if ({sv0, busy0, j0, k0, sv1, busy1, j1, k1} !== {2'b01, 8'h00, 2'b01, 8'h00} || idx0 !== m_idx[AW-1:0]) begin
         n_fail++; $display("FAIL %s check_cycle step %0d: sv/busy/j/k=%b%b%b%b idx=%0d", tag, m_idx, sv0, busy0, j0, k0, idx0);
      end
      if (eq != t && !m_mis) begin m_mis = 1; m_err = m_idx; end
      if (m_idx != m_last) m_idx = (m_idx + 1) % D;
      else if (m_loop) m_idx = 0;
      else m_end = 1;
      @(posedge clk); #1;
      m_cyc += 2;
      n_cmp++;
      if (mis0 !== m_mis || err0 !== m_err[AW-1:0] || mis1 !== m_mis || err1 !== m_err[AW-1:0]) begin
         n_fail++; $display("FAIL %s mismatch_rec: got %b@%0d / %b@%0d want %b@%0d", tag, mis0, err0, mis1, err1, m_mis, m_err);
      end
      n_cmp++;
      if (done0 !== m_end || done1 !== m_end) begin
         n_fail++; $display("FAIL %s done_flag: got %b/%b want %b", tag, done0, done1, m_end);
      end
   endtask

   task automatic run_to_end(input string tag);
      int guard = 0;
      while (!m_end && guard < 40) begin
         do_step(tag);
         guard++;
      end
      n_cmp++;
      if (!m_end) begin
         n_fail++; $display("FAIL %s timeout: run did not end within %0d steps", tag, guard);
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({done0, done1, busy0, busy1} !== 4'b0000) begin
         n_fail++; $display("FAIL %s after_done: done/busy=%b want 0000", tag, {done0, done1, busy0, busy1});
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; bank_rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({j0, k0, sv0, idx0, busy0, done0, mis0, err0} !== '0 || {j1, k1, sv1, idx1, busy1, done1, mis1, err1} !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got %h / %h want 0", {j0, k0, sv0, idx0, busy0, done0, mis0, err0}, {j1, k1, sv1, idx1, busy1, done1, mis1, err1});
      end
      rst = 1'b0; bank_rst = 1'b0;
   endtask

   // Counter 0,1,2,3 on both encodings, with the excitation table spelled out.
   task automatic test_counter();
      logic [W-1:0] tj [4] = '{4'b0000, 4'b0001, 4'b0010, 4'b0001};
      logic [W-1:0] tk [4] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000};
      for (int a = 0; a < 4; a++) write_mem(a, a[W-1:0]);
      stuck = '0;
      start_run(3, 0);
      for (int s = 0; s < 4; s++) begin
         n_cmp++;
         if (j0 !== tj[s] || k0 !== tk[s]) begin
            n_fail++; $display("FAIL counter_table step %0d: got %b/%b want %b/%b", s, j0, k0, tj[s], tk[s]);
         end
         if (s == 2) begin
            n_cmp++;
            if (j1 !== 4'b0011 || k1 !== 4'b0011) begin
               n_fail++; $display("FAIL toggle_step2: got %b/%b want 0011/0011", j1, k1);
            end
         end
         do_step("counter");
      end
      n_cmp++;
      if (done0 !== 1'b1 || m_cyc != 8 || bq0 !== 4'd3 || bq1 !== 4'd3 || mis0 !== 1'b0) begin
         n_fail++; $display("FAIL counter_end: done=%b cycles=%0d q=%h/%h mis=%b want 1 8 3/3 0", done0, m_cyc, bq0, bq1, mis0);
      end
      run_to_end("counter");
   endtask

   // Bit 1 stuck at 0: steps 2 and 3 fail, only the first is recorded.
   task automatic test_fault();
      stuck = 4'b0010;
      start_run(3, 0);
      run_to_end("fault");
      n_cmp++;
      if (mis0 !== 1'b1 || err0 !== 3'd2 || mis1 !== 1'b1 || err1 !== 3'd2) begin
         n_fail++; $display("FAIL fault_err_idx: got %b@%0d / %b@%0d want 1@2", mis0, err0, mis1, err1);
      end
      stuck = '0;
   endtask

   task automatic test_loop_abort();
      write_mem(0, 4'h5);
      write_mem(1, 4'hA);
      start_run(1, 1);
      for (int s = 0; s < 3; s++) do_step("loop");
      @(posedge clk); #1;            // CHECK of step 1
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      n_cmp++;
      if ({busy0, busy1, done0, done1, sv0, j0, k0, j1, k1} !== '0) begin
         n_fail++; $display("FAIL abort_idle: busy/done/sv/j/k=%b want 0", {busy0, busy1, done0, done1, sv0, j0, k0, j1, k1});
      end
      @(posedge clk); #1;
      n_cmp++;
      if (done0 !== 1'b0 || busy0 !== 1'b0) begin
         n_fail++; $display("FAIL abort_no_done: done=%b busy=%b want 0 0", done0, busy0);
      end
      start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      n_cmp++;
      if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
         n_fail++; $display("FAIL start_abort_same_cycle: busy=%b/%b want 0", busy0, busy1);
      end
   endtask

   task automatic test_reset_mid_run();
      write_mem(0, 4'h1); write_mem(1, 4'h2); write_mem(2, 4'h3); write_mem(3, 4'h0);
      stuck = 4'b0001;
      start_run(3, 0);
      do_step("rstmid");
      do_step("rstmid");              // now in DRIVE of step 2, mismatch set
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; stuck = '0;
      n_cmp++;
      if ({j0, k0, sv0, idx0, busy0, done0, mis0, err0} !== '0 || {busy1, mis1, idx1} !== '0) begin
         n_fail++; $display("FAIL reset_mid_run: got %h want 0", {j0, k0, sv0, idx0, busy0, done0, mis0, err0});
      end
      start_run(3, 0);
      run_to_end("rstmid_rerun");
   endtask

   task automatic test_busy_writes();
      start_run(3, 0);
      load_en = 1'b1; load_addr = 3'd1; load_data = 4'hF; start = 1'b1;   // both ignored
      do_step("busy");
      start = 1'b1;
      do_step("busy");
      while (!m_end) do_step("busy");
      // DONE cycle: start ignored, load honoured.
      start = 1'b1; load_en = 1'b1; load_addr = 3'd3; load_data = 4'h9;
      @(posedge clk); #1;
      start = 1'b0; load_en = 1'b0; mem_m[3] = 4'h9;
      n_cmp++;
      if (busy0 !== 1'b0 || busy1 !== 1'b0 || idx0 !== 3'd3) begin
         n_fail++; $display("FAIL start_in_done: busy=%b idx=%0d want 0 3", busy0, idx0);
      end
      start_run(3, 0);
      run_to_end("busy_rerun");
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         for (int a = 0; a < D; a++) write_mem(a, W'($urandom_range(0, 15)));
         stuck = (r % 2 == 1) ? W'(1 << $urandom_range(0, W - 1)) : '0;
         // Write step 0 in the start cycle; the new value must be used.
         load_en = 1'b1; load_addr = '0; load_data = W'($urandom_range(0, 15));
         mem_m[0] = load_data;
         start_run($urandom_range(0, D - 1), 0);
         run_to_end("random");
      end
      stuck = '0;
   endtask

   initial begin
      test_reset();
      test_counter();
      test_fault();
      test_loop_abort();
      test_reset_mid_run();
      test_busy_writes();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/jk_sequence_driver.md
Name: jk_sequence_driver

Overview:
- Drives an external bank of WIDTH JK flip-flops through a programmed sequence of target states.
- Per step, computes J/K excitation from the bank's current Q and the stored target, applies it for one clock, then checks that Q reached the target.
- Sits on the input side of the JK register bank (the excitation end); the bank's Q is fed back as q_in.

Parameters:
- WIDTH, 4, bits in the JK bank / target word
- DEPTH, 8, sequence memory entries
- AW, 3, address width; DEPTH = 2**AW
- USE_TOGGLE, 0, 1 = encode every bit change as J=1,K=1 (complement); 0 = set/clear encoding

Ports:
- clk  in  1  clock; external JK bank is on the same clock
- rst  in  1  synchronous, active-high reset
- load_en  in  1  write load_data to memory[load_addr]; ignored while busy
- load_addr  in  AW  memory write address
- load_data  in  WIDTH  target state
- last_addr  in  AW  index of final step; sampled on accepted start
- loop  in  1  1 = wrap from last_addr back to 0; sampled on accepted start
- start  in  1  begin sequence at index 0; ignored while busy
- abort  in  1  stop the sequence
- q_in  in  WIDTH  Q of the external JK bank
- j_out  out  WIDTH  J excitation
- k_out  out  WIDTH  K excitation
- step_valid  out  1  high while j_out/k_out carry a step
- step_idx  out  AW  current step index
- busy  out  1  high in DRIVE or CHECK
- done  out  1  one-cycle pulse at normal sequence end
- mismatch  out  1  sticky; set when a CHECK fails
- err_idx  out  AW  index of the first failing step

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - Outputs: j_out=0, k_out=0, step_valid=0, step_idx=0, busy=0, done=0, mismatch=0, err_idx=0.
  - Memory contents are retained; reset does not clear them.
  - Reset has priority over all other inputs, including during DRIVE or CHECK.
- States: IDLE, DRIVE, CHECK, DONE.
- IDLE:
  - start=1: capture last_addr and loop, set idx=0, clear mismatch and err_idx, go to DRIVE.
  - load_en is honoured only in IDLE and DONE.
- DRIVE (1 cycle):
  - step_valid=1.
  - j_out/k_out are a combinational function of q_in and mem[idx]; the external bank captures them at the closing edge.
  - Next state is CHECK.
- Excitation per bit, with USE_TOGGLE=0:
  - q=0 to t=0: J=0, K=0
  - q=0 to t=1: J=1, K=0
  - q=1 to t=0: J=0, K=1
  - q=1 to t=1: J=0, K=0
- Excitation with USE_TOGGLE=1: any change gives J=1, K=1; no change gives J=0, K=0.
- Outside DRIVE: j_out=k_out=0 (bank holds) and step_valid=0.
- CHECK (1 cycle):
  - If q_in != mem[idx] and mismatch=0: set mismatch and err_idx=idx. Later failures leave err_idx unchanged.
  - If idx != last_addr: idx+1, go to DRIVE.
  - If idx == last_addr and loop=1: idx=0, go to DRIVE.
  - If idx == last_addr and loop=0: go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. A start in DONE is ignored.
- Step latency is 2 cycles; an N-step non-looping run takes 2N cycles from start acceptance to done.
- abort=1 in DRIVE or CHECK:
  - Go to IDLE at the next edge with no done pulse.
  - A DRIVE cycle coinciding with abort still presents its excitation.
- Simultaneous start and abort in IDLE: abort wins and the run does not start.
- Simultaneous load_en and start in IDLE: the write commits and the run starts. A step-0 target written that same cycle is the value used.
- step_idx mirrors idx in all states. Index arithmetic wraps modulo DEPTH.

Decomposition:
- Package jk_seq_pkg holds:
  - the state enum (IDLE, DRIVE, CHECK, DONE)
  - the 2-bit JK code constants: HOLD=00, CLR=01, SET=10, TGL=11
- Sub-module jk_excite: purely combinational, parameter WIDTH/USE_TOGGLE, inputs (q, t), outputs (j, k).
- Memory is a DEPTH x WIDTH register array inside the top module.

Test Plan:
1. Counter run, USE_TOGGLE=0, JK bank model reset to 0, load 0,1,2,3, last_addr=3, loop=0, start:
   - DRIVE outputs are j/k = 0000/0000, 0001/0000, 0010/0001, 0001/0000.
   - Bank reads 3; done pulses 8 cycles after start acceptance; mismatch=0.
2. USE_TOGGLE=1, same sequence: step 2 (0001 to 0010) gives j=0011, k=0011; final Q=3; mismatch=0.
3. Fault: bank model bit 1 stuck at 0, sequence 0,1,2,3 → mismatch=1 at CHECK of step 2, err_idx=2; it stays 2 after the step-3 failure, and done still pulses.
4. Loop with last_addr=1, loop=1, targets 5,A:
   - Outputs alternate continuously with step_idx 0,0,1,1,0,...
   - abort in a CHECK cycle → IDLE next edge, busy=0, no done, j/k=0.
5. rst asserted during DRIVE of step 2: next cycle everything is 0 and state is IDLE; restart without reloading runs the retained memory correctly.
6. Writes: load_en while busy does not alter memory (verified on the next run); start during busy or DONE is ignored (no restart, idx unchanged).
